// File: rtl/fsm_decod.sv
// Receiver for the 12 kHz trinary line code: measures high/low runs, assembles 24
// symbols into 12 trits and checks the frame against the local trinary address.
module fsm_decod #(
    parameter int SHORT_MIN = 2,
    parameter int SHORT_MAX = 7,
    parameter int LONG_MIN  = 9,
    parameter int LONG_MAX  = 15,
    parameter int SYNC_MIN  = 64,
    parameter int IDLE_MAX  = 255
) (
    input  logic       clk_12kHz,
    input  logic       rst,
    input  logic       dado_in,
    input  logic [7:0] A_01,
    input  logic [7:0] A_F,
    output logic [3:0] dado_out,
    output logic       valid,
    output logic       vt,
    output logic       err
);

    typedef enum logic [2:0] {HUNT, WAIT_EDGE, HIGH, LOW, DONE} state_t;

    state_t      state, state_n;
    logic        sync1, line, line_d;
    logic [4:0]  hcnt, hcnt_n;
    logic [7:0]  lcnt, lcnt_n;
    logic [4:0]  sym_idx;
    logic [23:0] sym_sr;
    logic        h_long;

    logic        rise, h_short_w, h_long_w, l_short_w, l_long_w, sym_ok, ls_pair;
    logic        idx_clr, shift_en, hlong_ld, err_n, accept;
    logic [11:0] is_one, is_flt, is_bad;
    logic        addr_ok, frame_bad;
    logic [3:0]  rx_data;

    function automatic logic in_rng(input int w, input int lo, input int hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // Run counters track the synchronised line in every state.
    always_comb begin
        hcnt_n    = line ? ((hcnt == 5'd31) ? hcnt : hcnt + 5'd1) : 5'd0;
        lcnt_n    = line ? 8'd0 : ((lcnt == 8'hFF) ? lcnt : lcnt + 8'd1);
        rise      = line & ~line_d;
        h_short_w = in_rng(int'(hcnt), SHORT_MIN, SHORT_MAX);
        h_long_w  = in_rng(int'(hcnt), LONG_MIN, LONG_MAX);
        l_short_w = in_rng(int'(lcnt), SHORT_MIN, SHORT_MAX);
        l_long_w  = in_rng(int'(lcnt), LONG_MIN, LONG_MAX);
        sym_ok    = h_long ? l_short_w : l_long_w;
        // Second symbol of a trit being S after an L makes the illegal LS pair.
        ls_pair   = sym_idx[0] & sym_sr[0] & ~h_long;
    end

    // Symbol k of the frame sits at sym_sr[23-k]; trit b uses symbols 2b and 2b+1.
    always_comb begin
        is_one  = '0;
        is_flt  = '0;
        is_bad  = '0;
        addr_ok = 1'b1;
        for (int b = 0; b < 12; b++) begin
            is_one[b] = sym_sr[23-2*b] & sym_sr[22-2*b];
            is_flt[b] = ~sym_sr[23-2*b] & sym_sr[22-2*b];
            is_bad[b] = sym_sr[23-2*b] & ~sym_sr[22-2*b];
        end
        for (int i = 0; i < 8; i++) begin
            if (A_F[i]) begin
                if (!is_flt[i]) addr_ok = 1'b0;
            end else if (is_flt[i] || is_bad[i] || (is_one[i] != A_01[i])) begin
                addr_ok = 1'b0;
            end
        end
        frame_bad = (|is_bad) | (|is_flt[11:8]);
        rx_data   = {is_one[8], is_one[9], is_one[10], is_one[11]};
    end

    always_comb begin
        state_n  = state;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        hlong_ld = 1'b0;
        err_n    = 1'b0;
        accept   = 1'b0;
        case (state)
            HUNT: begin
                if (int'(lcnt_n) >= SYNC_MIN) begin
                    state_n = WAIT_EDGE;
                    idx_clr = 1'b1;
                end
            end
            WAIT_EDGE: begin
                if (rise) state_n = HIGH;
            end
            HIGH: begin
                if (line) begin
                    if (int'(hcnt_n) > LONG_MAX) begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                    end
                end else if (h_short_w || h_long_w) begin
                    hlong_ld = 1'b1;
                    state_n  = LOW;
                end else begin
                    err_n   = 1'b1;
                    state_n = HUNT;
                end
            end
            LOW: begin
                if (line) begin
                    if ((sym_idx < 5'd24) && sym_ok && !ls_pair) begin
                        shift_en = 1'b1;
                        state_n  = HIGH;
                    end else begin
                        err_n   = 1'b1;
                        state_n = HUNT;
                    end
                end else if (int'(lcnt_n) == SYNC_MIN) begin
                    // Outputs are registered, so the frame is judged on the edge
                    // into DONE and valid/err are visible during the DONE cycle.
                    if ((sym_idx == 5'd24) && !h_long) begin
                        state_n = DONE;
                        err_n   = frame_bad;
                        accept  = !frame_bad && addr_ok;
                    end else begin
                        err_n   = 1'b1;
                        state_n = WAIT_EDGE;
                        idx_clr = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = WAIT_EDGE;
                idx_clr = 1'b1;
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk_12kHz or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            sync1    <= 1'b0;
            line     <= 1'b0;
            line_d   <= 1'b0;
            hcnt     <= '0;
            lcnt     <= '0;
            sym_idx  <= '0;
            sym_sr   <= '0;
            h_long   <= 1'b0;
            dado_out <= '0;
            valid    <= 1'b0;
            vt       <= 1'b0;
            err      <= 1'b0;
        end else begin
            state  <= state_n;
            sync1  <= dado_in;
            line   <= sync1;
            line_d <= line;
            hcnt   <= hcnt_n;
            lcnt   <= lcnt_n;
            if (idx_clr)       sym_idx <= '0;
            else if (shift_en) sym_idx <= sym_idx + 5'd1;
            if (shift_en) sym_sr <= {sym_sr[22:0], h_long};
            if (hlong_ld) h_long <= h_long_w;
            valid <= accept;
            err   <= err_n;
            if (accept) dado_out <= rx_data;
            if (err_n || (int'(lcnt_n) == IDLE_MAX)) vt <= 1'b0;
            else if (accept)                         vt <= 1'b1;
        end
    end

endmodule
